// File: rtl/if_layer_refrac_controller_pkg.sv
// Shared constants and width helpers for the IF layer refractory controller.
package if_layer_refrac_controller_pkg;

  localparam int DEFAULT_REFRAC = 5;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter must hold 0..refrac; a REFRAC of 0 still gets a 1-bit counter.
  function automatic int cnt_width(input int refrac);
    int w;
    w = clog2(refrac + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/if_layer_refrac_controller_if.sv
// Spike bus between the IF neuron array, this controller and the next layer.
interface if_layer_refrac_controller_if #(
  parameter int NUM_OUTPUTS = 4
);
  // No handshake: spike_in and ts_en are levels sampled at every clk edge with no
  // backpressure; spike_out is a 1-clk pulse per accepted spike, and neuron_rst /
  // refrac_active are registered levels valid every cycle.
  logic                   ts_en;
  logic [NUM_OUTPUTS-1:0] spike_in;
  logic [NUM_OUTPUTS-1:0] spike_out;
  logic [NUM_OUTPUTS-1:0] neuron_rst;
  logic [NUM_OUTPUTS-1:0] refrac_active;

  modport master (
    output ts_en,
    output spike_in,
    input  spike_out,
    input  neuron_rst,
    input  refrac_active
  );

  modport slave (
    input  ts_en,
    input  spike_in,
    output spike_out,
    output neuron_rst,
    output refrac_active
  );
endinterface

// File: rtl/if_layer_refrac_controller_refrac_counter.sv
// Per-neuron refractory down-counter: loads REFRAC on acceptance, saturates at 0.
module refrac_counter
  import if_layer_refrac_controller_pkg::*;
#(
  parameter int REFRAC = DEFAULT_REFRAC
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic cnt_next_nz,
  output logic active
);

  localparam int CNT_W = cnt_width(REFRAC);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(REFRAC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // A load wins over a decrement in the same cycle.
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign cnt_next_nz = (cnt_next != '0);
  assign active      = (cnt != '0);

endmodule

// File: rtl/if_layer_refrac_controller.sv
// Reset/refractory controller for one IF layer: gates raw spikes, holds fired
// neurons in reset for REFRAC timesteps, optional lowest-index winner-take-all.
module if_layer_refrac_controller
  import if_layer_refrac_controller_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int REFRAC      = DEFAULT_REFRAC,
  parameter bit WTA_EN      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  if_layer_refrac_controller_if.slave bus
);

  logic [NUM_OUTPUTS-1:0] cnt_active;
  logic [NUM_OUTPUTS-1:0] cnt_next_nz;
  logic [NUM_OUTPUTS-1:0] elig;
  logic [NUM_OUTPUTS-1:0] acc;
  logic                   inhib;

  logic [NUM_OUTPUTS-1:0] spike_out_q;
  logic [NUM_OUTPUTS-1:0] neuron_rst_q;
  logic [NUM_OUTPUTS-1:0] refrac_active_q;

  // Eligibility uses the pre-edge count, so a spike on the cycle the count
  // reaches zero is still dropped.
  always_comb begin
    elig  = bus.spike_in & ~cnt_active;
    inhib = WTA_EN & (|elig);
    acc   = elig;
    if (WTA_EN) begin
      // Two's-complement trick isolates the lowest set bit.
      acc = elig & (~elig + NUM_OUTPUTS'(1));
    end
  end

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
    refrac_counter #(
      .REFRAC (REFRAC)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .load        (acc[i]),
      .dec         (bus.ts_en),
      .cnt_next_nz (cnt_next_nz[i]),
      .active      (cnt_active[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_out_q     <= '0;
      neuron_rst_q    <= '1;
      refrac_active_q <= '0;
    end else begin
      spike_out_q     <= acc;
      neuron_rst_q    <= acc | {NUM_OUTPUTS{inhib}} | cnt_next_nz;
      refrac_active_q <= cnt_next_nz;
    end
  end

  assign bus.spike_out     = spike_out_q;
  assign bus.neuron_rst    = neuron_rst_q;
  assign bus.refrac_active = refrac_active_q;

endmodule

// File: tb/tb_if_layer_refrac_controller.sv
// Scoreboard bench: four controller configurations share one stimulus stream and
// are checked cycle by cycle against an integer refractory model.
module tb_if_layer_refrac_controller;

  localparam int N    = 4;
  localparam int NDUT = 4;
  localparam int REF_T[NDUT] = '{5, 3, 0, 5};
  localparam bit WTA_T[NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic         clk;
  logic         rst;
  logic         ts_en;
  logic [N-1:0] spike_in;
  logic [11:0]  act[NDUT];

  logic [47:0]  exp_q[$];
  int           rem[NDUT][N];
  int           checks;
  int           errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    if_layer_refrac_controller_if #(.NUM_OUTPUTS(N)) bus ();

    assign bus.spike_in = spike_in;
    assign bus.ts_en    = ts_en;
    assign act[g]       = {bus.spike_out, bus.neuron_rst, bus.refrac_active};

    if_layer_refrac_controller #(
      .NUM_OUTPUTS (N),
      .REFRAC      (REF_T[g]),
      .WTA_EN      (WTA_T[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- reference model ----------------
  // rem[k][i] = timesteps neuron i of configuration k still has to sit out.
  task automatic model_step(input logic [N-1:0] sp, input logic ts, output logic [47:0] e);
    logic [N-1:0] el, ac, nr, ra;
    for (int k = 0; k < NDUT; k++) begin
      el = '0;
      for (int i = 0; i < N; i++) el[i] = sp[i] && (rem[k][i] == 0);
      ac = '0;
      if (WTA_T[k]) begin
        for (int i = 0; i < N; i++) begin
          if (el[i] && (ac == '0)) ac[i] = 1'b1;
        end
      end else begin
        ac = el;
      end
      for (int i = 0; i < N; i++) begin
        if (ac[i]) rem[k][i] = REF_T[k];
        else if (ts && rem[k][i] > 0) rem[k][i] = rem[k][i] - 1;
        ra[i] = (rem[k][i] > 0);
        nr[i] = ac[i] || (WTA_T[k] && (el != '0)) || ra[i];
      end
      e[k*12 +: 12] = {ac, nr, ra};
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < N; i++) rem[k][i] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] sp, input logic ts);
    logic [47:0] e;
    spike_in = sp;
    ts_en    = ts;
    model_step(sp, ts, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_vec(input string name, input int k, input logic [11:0] a, input logic [11:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d actual so=%b nrst=%b ra=%b required so=%b nrst=%b ra=%b",
               name, k, a[11:8], a[7:4], a[3:0], e[11:8], e[7:4], e[3:0]);
    end
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous reset state.
  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst      = 1'b1;
    spike_in = '0;
    ts_en    = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) check_vec("reset_async", k, act[k], 12'b0000_1111_0000);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) check_vec("reset_hold", k, act[k], 12'b0000_1111_0000);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < NDUT; k++) check_vec("cycle", k, act[k], e[k*12 +: 12]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    ts_en    = 1'b0;
    spike_in = '0;
    model_clear();
    #1;
    rst = 1'b1;
    #2;
    for (int k = 0; k < NDUT; k++) check_vec("reset_init", k, act[k], 12'b0000_1111_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Idle cycle after release clears neuron_rst.
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);

    // Single pulse on neuron 2 with ts_en always on.
    step(4'b0100, 1'b1);
    repeat (8) step(4'b0000, 1'b1);

    // Neuron 0 held high, ts_en every 4th clk.
    for (int c = 0; c < 44; c++) step(4'b0001, (c % 4) == 3);
    repeat (12) step(4'b0000, 1'b1);

    // Two simultaneous spikes: WTA picks bit 1.
    step(4'b1010, 1'b1);
    repeat (7) step(4'b0000, 1'b1);

    // Pulse on neuron 3.
    step(4'b1000, 1'b1);
    repeat (7) step(4'b0000, 1'b1);

    // Reset in the middle of a refractory period, then re-spike neuron 1.
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    apply_reset();
    step(4'b0010, 1'b1);
    repeat (7) step(4'b0000, 1'b1);

    // Boundary: spike held into the cycle the count reaches zero.
    step(4'b0001, 1'b1);
    repeat (8) step(4'b0001, 1'b1);
    step(4'b0000, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 149) == 0) apply_reset();
      step(N'($urandom_range(0, 15) & $urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
